// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_INCR          = 4;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {pc, inst} FIFO between fetch and decode.
module fetch_queue #(
  parameter int PW = 32,
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [PW-1:0] pc_i,
  input  logic [IW-1:0] inst_i,
  output logic [1:0]    count_o,
  output logic [PW-1:0] head_pc_o,
  output logic [IW-1:0] head_inst_o
);

  logic [1:0]    cnt_q, cnt_d;
  logic [PW-1:0] hpc_q, hpc_d;
  logic [IW-1:0] hin_q, hin_d;
  logic [PW-1:0] spc_q, spc_d;
  logic [IW-1:0] sin_q, sin_d;

  // Head is a register, so it keeps its last value once drained.
  always_comb begin
    cnt_d = cnt_q;
    hpc_d = hpc_q;
    hin_d = hin_q;
    spc_d = spc_q;
    sin_d = sin_q;
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      unique case (cnt_q)
        2'd0: begin
          if (push_i) begin
            hpc_d = pc_i;
            hin_d = inst_i;
            cnt_d = 2'd1;
          end
        end
        2'd1: begin
          if (push_i && pop_i) begin
            hpc_d = pc_i;
            hin_d = inst_i;
          end else if (push_i) begin
            spc_d = pc_i;
            sin_d = inst_i;
            cnt_d = 2'd2;
          end else if (pop_i) begin
            cnt_d = 2'd0;
          end
        end
        2'd2: begin
          if (pop_i) begin
            hpc_d = spc_q;
            hin_d = sin_q;
            if (push_i) begin
              spc_d = pc_i;
              sin_d = inst_i;
            end else begin
              cnt_d = 2'd1;
            end
          end
        end
        default: cnt_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hpc_q <= '0;
      hin_q <= '0;
      spc_q <= '0;
      sin_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      hpc_q <= hpc_d;
      hin_q <= hin_d;
      spc_q <= spc_d;
      sin_q <= sin_d;
    end
  end

  assign count_o     = cnt_q;
  assign head_pc_o   = hpc_q;
  assign head_inst_o = hin_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, redirect/fault FSM and 2-deep fetch queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH_LENGTH   = 32,
  parameter int INST_WIDTH_LENGTH = 32,
  parameter logic [PC_WIDTH_LENGTH-1:0] RESET_PC =
    PC_WIDTH_LENGTH'(DEFAULT_RESET_PC)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [PC_WIDTH_LENGTH-1:0]   imem_pc,
  input  logic [INST_WIDTH_LENGTH-1:0] imem_inst,
  input  logic                         redirect_valid,
  input  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc,
  output logic                         if_valid,
  input  logic                         if_ready,
  output logic [PC_WIDTH_LENGTH-1:0]   if_pc,
  output logic [INST_WIDTH_LENGTH-1:0] if_inst,
  output logic                         if_fault,
  output logic [PC_WIDTH_LENGTH-1:0]   fault_pc
);

  fetch_state_e               state_q, state_d;
  logic [PC_WIDTH_LENGTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH_LENGTH-1:0] fpc_q, fpc_d;
  logic [1:0]                 count;
  logic                       push, pop, aligned;

  assign aligned = (redirect_pc[1:0] == 2'b00);
  assign pop     = if_valid & if_ready & ~redirect_valid;
  assign push    = (state_q == RUN) & ~redirect_valid &
                   ((count < 2'd2) | pop);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fpc_d   = fpc_q;
    if (redirect_valid) begin
      if (aligned) begin
        pc_d    = redirect_pc;
        state_d = RUN;
      end else begin
        fpc_d   = redirect_pc;
        state_d = FAULT;
      end
    end else if (push) begin
      pc_d = pc_q + PC_WIDTH_LENGTH'(PC_INCR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      fpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fpc_q   <= fpc_d;
    end
  end

  fetch_queue #(
    .PW (PC_WIDTH_LENGTH),
    .IW (INST_WIDTH_LENGTH)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .pc_i        (pc_q),
    .inst_i      (imem_inst),
    .count_o     (count),
    .head_pc_o   (if_pc),
    .head_inst_o (if_inst)
  );

  assign imem_pc  = pc_q;
  assign if_valid = (count != 2'd0);
  assign if_fault = (state_q == FAULT);
  assign fault_pc = fpc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a combinational memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_fault;
  logic [31:0] fault_pc;

  int tests_run    = 0;
  int tests_failed = 0;
  int hs_cnt       = 0;
  logic [31:0] sb[$];

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_pc        (imem_pc),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_fault       (if_fault),
    .fault_pc       (fault_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    case (pc)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      32'hC:   return 32'h44;
      default: return pc ^ 32'hC0DE_0003;
    endcase
  endfunction

  assign imem_inst = inst_of(imem_pc);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Handshake monitor: compares each accepted head against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && if_valid && if_ready && !redirect_valid) begin
      hs_cnt++;
      if (sb.size() == 0) begin
        chk("sb_underflow", if_pc, 32'hXXXX_XXXX);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        chk("hs_pc", if_pc, e);
        chk("hs_inst", if_inst, inst_of(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
  endtask

  task automatic run_ready(input int n);
    if_ready = 1'b1;
    repeat (n) tick();
    if_ready = 1'b0;
  endtask

  task automatic drain_check(input string tag, input int n);
    chk({tag, "_hs"}, 32'(hs_cnt), 32'(n));
    chk({tag, "_sb"}, 32'(sb.size()), 32'd0);
    hs_cnt = 0;
    sb.delete();
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
    sb.delete();
    hs_cnt = 0;
  endtask

  initial begin
    int vcnt;
    rst_n          = 1'b0;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #2;
    chk("rst_valid", 32'(if_valid), 32'd0);
    tick();
    tick();
    chk("rst_pc", imem_pc, 32'h0);
    chk("rst_fault", 32'(if_fault), 32'd0);
    chk("rst_fpc", fault_pc, 32'h0);
    chk("rst_ifpc", if_pc, 32'h0);
    chk("rst_ifinst", if_inst, 32'h0);
    chk("rst_hold_valid", 32'(if_valid), 32'd0);

    // Streaming from reset
    rst_n = 1'b1;
    expect_run(32'h0, 4);
    chk("t1_valid0", 32'(if_valid), 32'd0);
    tick();
    chk("t1_valid1", 32'(if_valid), 32'd1);
    run_ready(4);
    drain_check("t1", 4);

    // Back-pressure from reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t2_imem_pc", imem_pc, 32'h8);
    chk("t2_head_pc", if_pc, 32'h0);
    chk("t2_head_inst", if_inst, 32'h11);
    expect_run(32'h0, 3);
    run_ready(3);
    drain_check("t2", 3);

    // Redirect while full with a concurrent handshake
    if_ready = 1'b1;
    redirect(32'h100);
    chk("t3_imem_pc", imem_pc, 32'h100);
    chk("t3_valid0", 32'(if_valid), 32'd0);
    expect_run(32'h100, 2);
    tick();
    chk("t3_valid1", 32'(if_valid), 32'd1);
    chk("t3_pc", if_pc, 32'h100);
    run_ready(2);
    drain_check("t3", 2);

    // Misaligned redirect parks the unit
    redirect(32'h102);
    chk("t4_fault", 32'(if_fault), 32'd1);
    chk("t4_fpc", fault_pc, 32'h102);
    chk("t4_valid", 32'(if_valid), 32'd0);
    if_ready = 1'b1;
    vcnt = 0;
    repeat (10) begin
      tick();
      if (if_valid) vcnt++;
    end
    chk("t4_novalid", 32'(vcnt), 32'd0);
    chk("t4_fault_hold", 32'(if_fault), 32'd1);
    redirect(32'h200);
    chk("t4_unfault", 32'(if_fault), 32'd0);
    chk("t4_imem_pc", imem_pc, 32'h200);
    expect_run(32'h200, 2);
    tick();
    chk("t4_pc", if_pc, 32'h200);
    run_ready(2);
    drain_check("t4", 2);

    // PC wrap-around
    if_ready = 1'b1;
    redirect(32'hFFFF_FFFC);
    expect_run(32'hFFFF_FFFC, 3);
    tick();
    chk("t5_valid", 32'(if_valid), 32'd1);
    run_ready(3);
    drain_check("t5", 3);

    // Reset mid-stream with a full queue
    repeat (3) tick();
    chk("t6_full_valid", 32'(if_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(if_valid), 32'd0);
    chk("t6_rst_pc", imem_pc, 32'h0);
    tick();
    chk("t6_rst_hold", 32'(if_valid), 32'd0);
    rst_n = 1'b1;
    expect_run(32'h0, 2);
    tick();
    chk("t6_valid", 32'(if_valid), 32'd1);
    chk("t6_pc", if_pc, 32'h0);
    run_ready(2);
    drain_check("t6", 2);

    // Reset clears FAULT
    redirect(32'h6);
    chk("t7_fault", 32'(if_fault), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_fault", 32'(if_fault), 32'd0);
    chk("t7_rst_fpc", fault_pc, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly upstream of the instruction memory. Owns the program counter, drives the word-aligned fetch address to the memory, and captures the combinationally returned instruction into a 2-entry queue. The decode stage drains the queue through a valid/ready handshake. Control-flow redirects (branch/jump/trap) flush the queue and restart fetch; a misaligned redirect target parks the unit in a fault state.

## Interface
- PC_WIDTH_LENGTH, 32, width of PC and fetch address
- INST_WIDTH_LENGTH, 32, instruction width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- imem_pc  out  PC_WIDTH_LENGTH  fetch address to instruction memory (equals pc_q)
- imem_inst  in  INST_WIDTH_LENGTH  instruction returned combinationally for imem_pc
- redirect_valid  in  1  redirect request from execute/trap logic
- redirect_pc  in  PC_WIDTH_LENGTH  redirect target
- if_valid  out  1  queue head valid
- if_ready  in  1  decode accepts head this cycle
- if_pc  out  PC_WIDTH_LENGTH  PC of head instruction
- if_inst  out  INST_WIDTH_LENGTH  head instruction
- if_fault  out  1  unit in FAULT state
- fault_pc  out  PC_WIDTH_LENGTH  offending redirect target

## Operation
- States: RUN, FAULT.
- RUN: each cycle, push = (count < 2) or pop; pop = if_valid & if_ready. On push, {pc_q, imem_inst} is written to the queue tail and pc_q <= pc_q + 4 (modulo 2^PC_WIDTH_LENGTH; 32'hFFFF_FFFC wraps to 0).
- Full (count == 2) with no pop: no push, pc_q holds, and imem_pc remains stable.
- Full with pop: push and pop occur on the same edge, and count stays 2.
- Empty: if_valid = 0. if_pc and if_inst are don't-care but held at the last value.
- Redirect (highest priority, any state): on the edge where redirect_valid = 1, the queue is flushed (count <= 0), and push and pop are suppressed. The fetch unit ignores any handshake on that edge; decode is responsible for killing its own copy.
  - If redirect_pc[1:0] == 0: pc_q <= redirect_pc and state <= RUN.
  - Otherwise: fault_pc <= redirect_pc, state <= FAULT, and pc_q holds.
- FAULT: no push, queue empty, if_fault = 1. The unit leaves FAULT only on an aligned redirect.
- pc_q[1:0] is always 0, so the memory never sees a misaligned address.

## Timing
- Reset (async, rst_n = 0) sets: pc_q = RESET_PC, count = 0, state = RUN, if_valid = 0, if_fault = 0, fault_pc = 0, if_pc = 0, if_inst = 0. These values hold while rst_n is low.
- Reset asserted mid-operation clears all state immediately, including any queued entries and FAULT.
- Fetch latency: imem_pc is presented in cycle N, and the instruction appears at the queue head (if_valid = 1) in cycle N+1.
- Throughput: 1 instruction per cycle while if_ready is held high.
- Redirect penalty: redirect at edge E; imem_pc = target in the cycle after E; if_valid = 1 one cycle later.
- if_valid, if_pc and if_inst are driven from registers only, with no combinational path from if_ready.

## Structure
- Shared package fetch_pkg holds:
  - state encoding (RUN = 1'b0, FAULT = 1'b1)
  - default RESET_PC
  - PC increment constant 4
  - NOP encoding 32'h0000_0013, used by downstream stages
- Sub-module fetch_queue: 2-entry FIFO of {pc, inst} with push, pop, flush, count, head outputs, and the same clk/rst_n.
- fetch_unit contains the PC register, next-PC logic, FSM, and the queue instance.

## Test plan
- Reset release, if_ready = 1, memory words 0..3 = 32'h11, 32'h22, 32'h33, 32'h44 → if_valid rises 1 cycle after release, and if_pc/if_inst run 0/11, 4/22, 8/33, C/44 on consecutive cycles.
- if_ready = 0 for 5 cycles from reset → count saturates at 2, imem_pc holds at 32'h8, and head stays 0/11. Raising if_ready then delivers 0, 4, 8 back-to-back with no bubble.
- Queue full and redirect_valid = 1 with redirect_pc = 32'h100 and if_ready = 1 on the same edge → queue empties, imem_pc = 32'h100 the next cycle, and the next if_valid carries pc 32'h100.
- Redirect to 32'h102 → if_fault = 1, fault_pc = 32'h102, and if_valid stays 0 for 10 cycles. A later redirect to 32'h200 clears if_fault and fetches 32'h200.
- Redirect to 32'hFFFF_FFFC with if_ready = 1 → if_pc sequence FFFF_FFFC, 0000_0000, 0000_0004.
- rst_n pulsed low mid-stream while the queue holds 2 entries → if_valid = 0 immediately, and fetch restarts at RESET_PC after release.
